// File: rtl/aq_djpeg_coef_buffer_if.sv
// Huffman-side write and IDCT-side read signals of the JPEG coefficient ping-pong buffer.
interface aq_djpeg_coef_buffer_if;
  logic        ProcessInit;
  logic        HuffmanEnable;
  logic [5:0]  HuffmanCount;
  logic [15:0] HuffmanData;
  logic        HuffmanEndEnable;
  logic        HuffmanReady;
  logic        Overflow;
  logic        DataOutEnable;
  logic        DataOutRead;
  logic [4:0]  DataOutAddress;
  logic [15:0] DataOutA;
  logic [15:0] DataOutB;

  modport master (
    output ProcessInit, HuffmanEnable, HuffmanCount, HuffmanData, HuffmanEndEnable,
    output DataOutRead, DataOutAddress,
    input  HuffmanReady, Overflow, DataOutEnable, DataOutA, DataOutB
  );

  modport slave (
    input  ProcessInit, HuffmanEnable, HuffmanCount, HuffmanData, HuffmanEndEnable,
    input  DataOutRead, DataOutAddress,
    output HuffmanReady, Overflow, DataOutEnable, DataOutA, DataOutB
  );
endinterface

// File: rtl/aq_djpeg_coef_buffer.sv
// Two-page ping-pong coefficient buffer between Huffman decode (zigzag writes) and IDCT (raster reads).
// Optional input saturation to -2048..2047 when AQ_DJPEG_COEF_CLAMP_EN is defined.
module aq_djpeg_coef_buffer (
  input  logic                   clk,
  input  logic                   rst,
  aq_djpeg_coef_buffer_if.slave  bus
);

  logic [15:0]      mem [2][64];
  logic [1:0][63:0] mask;
  logic [1:0]       full, full_n;
  logic             wp, rp, wp_n, rp_n;
  logic             ovf, doe;
  logic [15:0]      a_q, b_q;
  logic             ready, wr, cl, rel, init;
  logic [5:0]       raster, addr_a, addr_b;
  logic [15:0]      wdata;

  function automatic logic [5:0] dezigzag(input logic [5:0] zz);
    logic [5:0] r;
    case (zz)
      6'd0:  r = 6'd0;   6'd1:  r = 6'd1;   6'd2:  r = 6'd8;   6'd3:  r = 6'd16;
      6'd4:  r = 6'd9;   6'd5:  r = 6'd2;   6'd6:  r = 6'd3;   6'd7:  r = 6'd10;
      6'd8:  r = 6'd17;  6'd9:  r = 6'd24;  6'd10: r = 6'd32;  6'd11: r = 6'd25;
      6'd12: r = 6'd18;  6'd13: r = 6'd11;  6'd14: r = 6'd4;   6'd15: r = 6'd5;
      6'd16: r = 6'd12;  6'd17: r = 6'd19;  6'd18: r = 6'd26;  6'd19: r = 6'd33;
      6'd20: r = 6'd40;  6'd21: r = 6'd48;  6'd22: r = 6'd41;  6'd23: r = 6'd34;
      6'd24: r = 6'd27;  6'd25: r = 6'd20;  6'd26: r = 6'd13;  6'd27: r = 6'd6;
      6'd28: r = 6'd7;   6'd29: r = 6'd14;  6'd30: r = 6'd21;  6'd31: r = 6'd28;
      6'd32: r = 6'd35;  6'd33: r = 6'd42;  6'd34: r = 6'd49;  6'd35: r = 6'd56;
      6'd36: r = 6'd57;  6'd37: r = 6'd50;  6'd38: r = 6'd43;  6'd39: r = 6'd36;
      6'd40: r = 6'd29;  6'd41: r = 6'd22;  6'd42: r = 6'd15;  6'd43: r = 6'd23;
      6'd44: r = 6'd30;  6'd45: r = 6'd37;  6'd46: r = 6'd44;  6'd47: r = 6'd51;
      6'd48: r = 6'd58;  6'd49: r = 6'd59;  6'd50: r = 6'd52;  6'd51: r = 6'd45;
      6'd52: r = 6'd38;  6'd53: r = 6'd31;  6'd54: r = 6'd39;  6'd55: r = 6'd46;
      6'd56: r = 6'd53;  6'd57: r = 6'd60;  6'd58: r = 6'd61;  6'd59: r = 6'd54;
      6'd60: r = 6'd47;  6'd61: r = 6'd55;  6'd62: r = 6'd62;  6'd63: r = 6'd63;
      default: r = 6'd0;
    endcase
    return r;
  endfunction

  always_comb begin
    wdata = bus.HuffmanData;
`ifdef AQ_DJPEG_COEF_CLAMP_EN
    if ($signed(bus.HuffmanData) > 16'sd2047)       wdata = 16'h07FF;
    else if ($signed(bus.HuffmanData) < -16'sd2048) wdata = 16'hF800;
`endif
  end

  // A page is writable only while not full; a release needs the read page to hold a block.
  always_comb begin
    init   = !rst || bus.ProcessInit;
    ready  = !full[wp];
    wr     = bus.HuffmanEnable && ready;
    cl     = bus.HuffmanEndEnable && ready;
    rel    = bus.DataOutRead && full[rp] && (bus.DataOutAddress == 5'd31);
    raster = dezigzag(bus.HuffmanCount);
    addr_a = {1'b0, bus.DataOutAddress};
    addr_b = {1'b1, bus.DataOutAddress};
    full_n = full;
    if (cl)  full_n[wp] = 1'b1;
    if (rel) full_n[rp] = 1'b0;
    wp_n   = wp ^ cl;
    rp_n   = rp ^ rel;
  end

  always_ff @(posedge clk) begin
    if (init) begin
      full <= '0;
      mask <= '0;
      wp   <= 1'b0;
      rp   <= 1'b0;
      ovf  <= 1'b0;
      doe  <= 1'b0;
      if (!rst) begin
        a_q <= '0;
        b_q <= '0;
      end
    end else begin
      full <= full_n;
      wp   <= wp_n;
      rp   <= rp_n;
      doe  <= full_n[rp_n];
      if ((bus.HuffmanEnable || bus.HuffmanEndEnable) && !ready) ovf <= 1'b1;
      // Read data for the releasing access is taken from the pre-release state.
      if (bus.DataOutRead) begin
        a_q <= mask[rp][addr_a] ? mem[rp][addr_a] : 16'h0000;
        b_q <= mask[rp][addr_b] ? mem[rp][addr_b] : 16'h0000;
      end
      if (rel) mask[rp] <= '0;
      if (wr)  mask[wp][raster] <= 1'b1;
    end
  end

  // Storage needs no reset: unwritten entries are masked to zero on read.
  always_ff @(posedge clk) begin
    if (wr && !init) mem[wp][raster] <= wdata;
  end

  assign bus.HuffmanReady  = ready;
  assign bus.Overflow      = ovf;
  assign bus.DataOutEnable = doe;
  assign bus.DataOutA      = a_q;
  assign bus.DataOutB      = b_q;

endmodule

// File: tb/tb_aq_djpeg_coef_buffer.sv
// Directed self-checking bench for the coefficient ping-pong buffer.
module tb_aq_djpeg_coef_buffer;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   failures = 0;
  logic [15:0] exp_blk [64];

  always #5 clk = ~clk;

  aq_djpeg_coef_buffer_if bus ();
  aq_djpeg_coef_buffer dut (.clk(clk), .rst(rst), .bus(bus.slave));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [5:0] zz, input logic [15:0] d, input logic endb);
    bus.HuffmanEnable = 1'b1; bus.HuffmanCount = zz; bus.HuffmanData = d;
    bus.HuffmanEndEnable = endb;
    tick;
    bus.HuffmanEnable = 1'b0; bus.HuffmanEndEnable = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a);
    bus.DataOutRead = 1'b1; bus.DataOutAddress = a;
    tick;
    bus.DataOutRead = 1'b0;
  endtask

  task automatic pinit;
    bus.ProcessInit = 1'b1;
    tick;
    bus.ProcessInit = 1'b0;
  endtask

  task automatic clear_exp;
    for (int i = 0; i < 64; i++) exp_blk[i] = 16'h0000;
  endtask

  task automatic read_block(input string tag);
    for (int i = 0; i < 32; i++) begin
      rd(5'(i));
      chk($sformatf("%s_a%0d", tag, i), bus.DataOutA, exp_blk[i]);
      chk($sformatf("%s_b%0d", tag, i), bus.DataOutB, exp_blk[i+32]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.ProcessInit = 0; bus.HuffmanEnable = 0; bus.HuffmanCount = 0; bus.HuffmanData = 0;
    bus.HuffmanEndEnable = 0; bus.DataOutRead = 0; bus.DataOutAddress = 0;
    tick; tick;
    chk("rst_ready", bus.HuffmanReady, 1);
    chk("rst_ovf", bus.Overflow, 0);
    chk("rst_doe", bus.DataOutEnable, 0);
    chk("rst_a", bus.DataOutA, 0);
    chk("rst_b", bus.DataOutB, 0);
    rst = 1'b1;
    tick;

    // basic block, DataOutEnable timing and release
    wr(6'd0, 16'h0010, 0);
    wr(6'd2, 16'h0005, 0);
    chk("b1_doe_pre", bus.DataOutEnable, 0);
    bus.HuffmanEndEnable = 1'b1; tick; bus.HuffmanEndEnable = 1'b0;
    chk("b1_doe", bus.DataOutEnable, 1);
    chk("b1_ready", bus.HuffmanReady, 1);
    clear_exp; exp_blk[0] = 16'h0010; exp_blk[8] = 16'h0005;
    read_block("b1");
    chk("b1_doe_rel", bus.DataOutEnable, 0);

    // both pages full: backpressure and overflow
    wr(6'd0, 16'h0111, 1);
    wr(6'd0, 16'h0222, 1);
    chk("ov_ready0", bus.HuffmanReady, 0);
    chk("ov_doe", bus.DataOutEnable, 1);
    chk("ov_ovf0", bus.Overflow, 0);
    wr(6'd1, 16'h0333, 0);
    chk("ov_ovf1", bus.Overflow, 1);
    rd(5'd31);
    chk("ov_ready1", bus.HuffmanReady, 1);
    chk("ov_doe2", bus.DataOutEnable, 1);
    rd(5'd0);
    chk("ov_blk2", bus.DataOutA, 16'h0222);
    rd(5'd1);
    chk("ov_drop", bus.DataOutA, 16'h0000);
    rd(5'd31);
    chk("ov_doe_rel", bus.DataOutEnable, 0);
    chk("ov_sticky", bus.Overflow, 1);
    pinit;
    chk("ov_init_clr", bus.Overflow, 0);

    // write and end in the same cycle
    wr(6'd63, 16'h1234, 1);
    chk("we_doe", bus.DataOutEnable, 1);
    rd(5'd31);
    chk("we_b31", bus.DataOutB, 16'h1234);
    chk("we_a31", bus.DataOutA, 16'h0000);
    chk("we_doe_rel", bus.DataOutEnable, 0);
    tick;
    chk("we_hold", bus.DataOutB, 16'h1234);

    // close and release in the same cycle; freed page reads zero
    wr(6'd1, 16'h0AAA, 1);
    wr(6'd5, 16'h0BBB, 0);
    rd(5'd1);
    chk("cc_x1", bus.DataOutA, 16'h0AAA);
    bus.HuffmanEndEnable = 1'b1; bus.DataOutRead = 1'b1; bus.DataOutAddress = 5'd31;
    tick;
    bus.HuffmanEndEnable = 1'b0; bus.DataOutRead = 1'b0;
    chk("cc_doe", bus.DataOutEnable, 1);
    chk("cc_ready", bus.HuffmanReady, 1);
    chk("cc_x31", bus.DataOutA, 16'h0000);
    rd(5'd2);
    chk("cc_y2", bus.DataOutA, 16'h0BBB);
    rd(5'd1);
    chk("cc_y1", bus.DataOutA, 16'h0000);
    wr(6'd0, 16'h0033, 1);
    rd(5'd31);
    chk("cc_doe_z", bus.DataOutEnable, 1);
    rd(5'd1);
    chk("cc_fresh", bus.DataOutA, 16'h0000);
    rd(5'd0);
    chk("cc_z0", bus.DataOutA, 16'h0033);
    rd(5'd31);
    chk("cc_doe_rel", bus.DataOutEnable, 0);

    // release attempt with nothing to read is ignored
    rd(5'd31);
    wr(6'd0, 16'h0044, 1);
    chk("ig_doe", bus.DataOutEnable, 1);
    rd(5'd0);
    chk("ig_a0", bus.DataOutA, 16'h0044);
    rd(5'd31);
    chk("ig_doe_rel", bus.DataOutEnable, 0);

    // de-zigzag mapping and last-write-wins
    clear_exp;
    wr(6'd3,  16'h0103, 0); exp_blk[16] = 16'h0103;
    wr(6'd4,  16'h00AA, 0);
    wr(6'd10, 16'h010A, 0); exp_blk[32] = 16'h010A;
    wr(6'd4,  16'h00BB, 0); exp_blk[9]  = 16'h00BB;
    wr(6'd27, 16'h011B, 0); exp_blk[6]  = 16'h011B;
    wr(6'd35, 16'h0123, 0); exp_blk[56] = 16'h0123;
    wr(6'd48, 16'h0130, 0); exp_blk[58] = 16'h0130;
    wr(6'd53, 16'h0135, 0); exp_blk[31] = 16'h0135;
    wr(6'd62, 16'h013E, 1); exp_blk[62] = 16'h013E;
    read_block("zz");
    chk("zz_doe_rel", bus.DataOutEnable, 0);

    // saturation (only with the clamp macro)
    wr(6'd0, 16'h7FFF, 0);
    wr(6'd1, 16'h8000, 0);
    wr(6'd2, 16'hFFFF, 0);
    wr(6'd3, 16'h0800, 1);
    rd(5'd0);
`ifdef AQ_DJPEG_COEF_CLAMP_EN
    chk("cl_pos", bus.DataOutA, 16'h07FF);
    rd(5'd1);
    chk("cl_neg", bus.DataOutA, 16'hF800);
    rd(5'd16);
    chk("cl_2048", bus.DataOutA, 16'h07FF);
`else
    chk("cl_pos", bus.DataOutA, 16'h7FFF);
    rd(5'd1);
    chk("cl_neg", bus.DataOutA, 16'h8000);
    rd(5'd16);
    chk("cl_2048", bus.DataOutA, 16'h0800);
`endif
    rd(5'd8);
    chk("cl_m1", bus.DataOutA, 16'hFFFF);
    rd(5'd31);
    chk("cl_doe_rel", bus.DataOutEnable, 0);

    // ProcessInit with one page full and one half written
    wr(6'd0, 16'h0055, 1);
    wr(6'd0, 16'h0066, 0);
    chk("pi_doe_pre", bus.DataOutEnable, 1);
    pinit;
    chk("pi_doe", bus.DataOutEnable, 0);
    chk("pi_ready", bus.HuffmanReady, 1);
    chk("pi_ovf", bus.Overflow, 0);
    rd(5'd0);
    chk("pi_a0", bus.DataOutA, 16'h0000);
    chk("pi_doe2", bus.DataOutEnable, 0);

    // reset with both pages full and overflow set
    wr(6'd0, 16'h0077, 1);
    wr(6'd5, 16'h0099, 1);
    wr(6'd1, 16'h0001, 0);
    chk("rs_ovf_pre", bus.Overflow, 1);
    rd(5'd0);
    chk("rs_a_pre", bus.DataOutA, 16'h0077);
    rst = 1'b0;
    tick;
    chk("rs_doe", bus.DataOutEnable, 0);
    chk("rs_ready", bus.HuffmanReady, 1);
    chk("rs_ovf", bus.Overflow, 0);
    chk("rs_a", bus.DataOutA, 16'h0000);
    rst = 1'b1;
    tick;
    rd(5'd2);
    chk("rs_read2", bus.DataOutA, 16'h0000);
    chk("rs_doe2", bus.DataOutEnable, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/aq_djpeg_coef_buffer.md
AQ_DJPEG_COEF_BUFFER -- requirements
Module: aq_djpeg_coef_buffer

Interface
REQ-001 SHALL have no parameters; all widths are fixed.
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 rst  input  1  reset; synchronous, active-low.
REQ-004 ProcessInit  input  1  per-image init; empties both pages.
REQ-005 HuffmanEnable  input  1  coefficient write strobe.
REQ-006 HuffmanCount  input  6  zigzag index (0..63) of the coefficient.
REQ-007 HuffmanData  input  16  signed dequantized coefficient.
REQ-008 HuffmanEndEnable  input  1  end-of-block; closes the current write page.
REQ-009 HuffmanReady  output  1  write page free; writes accepted.
REQ-010 Overflow  output  1  sticky; a write or end-of-block arrived while HuffmanReady was low.
REQ-011 DataOutEnable  output  1  a full block is available to the IDCT.
REQ-012 DataOutRead  input  1  IDCT read strobe.
REQ-013 DataOutAddress  input  5  IDCT read address (0..31).
REQ-014 DataOutA  output  16  coefficient at raster index DataOutAddress (rows 0..3).
REQ-015 DataOutB  output  16  coefficient at raster index DataOutAddress+32 (rows 4..7).

Function
REQ-016 SHALL hold two 64x16 ping-pong pages; each page has a write pointer bit, a read pointer bit, a full flag and a 64-bit written mask.
REQ-017 On HuffmanEnable && HuffmanReady, SHALL store HuffmanData in the write page at the raster position given by the standard JPEG de-zigzag of HuffmanCount (zz0->0, zz1->1, zz2->8, zz3->16, zz5->2, zz63->63), and SHALL set the matching mask bit.
REQ-018 When the same index is written twice in one block, the last write SHALL win.
REQ-019 Reads of entries whose mask bit is clear SHALL return 0; no clearing cycles are allowed.
REQ-020 On HuffmanEndEnable && HuffmanReady, SHALL mark the write page full and toggle the write pointer at that edge.
REQ-021 A write presented in the same cycle as HuffmanEndEnable SHALL be included in the closed block.
REQ-022 HuffmanReady SHALL equal NOT full(write page), combinationally from registered state.
REQ-023 HuffmanEnable or HuffmanEndEnable while HuffmanReady is low SHALL be dropped and SHALL set Overflow.
REQ-024 DataOutEnable SHALL be registered and equal full(read page); it first asserts the cycle after the closing edge.
REQ-025 On DataOutRead, SHALL sample DataOutAddress and present DataOutA/DataOutB from the read page on the next cycle (1-clock latency); outputs SHALL hold when DataOutRead is low.
REQ-026 DataOutRead with address 31 on a full read page SHALL, at that same edge, clear the page's full flag and mask and toggle the read pointer; the read data for that access SHALL still come from the released page.
REQ-027 DataOutRead while DataOutEnable is low SHALL be ignored for release purposes.
REQ-028 A page close on the write side and a release on the read side in the same cycle SHALL both take effect.
REQ-029 Write-page mask clearing SHALL occur on release, so a freshly freed page reads as all zero.
REQ-030 ProcessInit SHALL have priority over all other inputs and SHALL empty both pages, zero both pointers, clear both masks and clear Overflow.

Reset
REQ-031 While rst=0 at an edge, SHALL apply the ProcessInit state and set DataOutEnable=0, DataOutA=0, DataOutB=0, Overflow=0, HuffmanReady=1.
REQ-032 Reset mid-block SHALL discard all partially written and full pages without emitting any DataOutEnable.

Configuration
REQ-033 With AQ_DJPEG_COEF_CLAMP_EN defined, SHALL saturate HuffmanData to the range -2048..2047 before storage (for example, 0x7FFF stores 0x07FF and 0x8000 stores 0xF800).
REQ-034 Without AQ_DJPEG_COEF_CLAMP_EN, SHALL store HuffmanData unmodified.

Verification
REQ-035 Write zz0=0x0010, zz2=0x0005 then End; read addresses 0..31 -> DataOutEnable goes high one cycle after End, addr0 A=0x0010, addr8 A=0x0005, all others 0, then DataOutEnable goes low after the addr31 read.
REQ-036 Close two blocks without reading -> HuffmanReady=0; a third write is dropped and Overflow=1; reading addr31 restores HuffmanReady=1 on the next cycle.
REQ-037 Write zz63=0x1234 with End in the same cycle -> addr31 B=0x1234.
REQ-038 Page close and addr31 release in the same cycle with both pages busy -> DataOutEnable stays 1 and the next read returns the other block's data.
REQ-039 ProcessInit, or rst=0, asserted while one page is full and the other is half written -> DataOutEnable=0, HuffmanReady=1, Overflow=0, subsequent reads return 0.
REQ-040 With AQ_DJPEG_COEF_CLAMP_EN defined, write 0x7FFF at zz0 -> addr0 A=0x07FF; without the macro, addr0 A=0x7FFF.
